// File: rtl/z80_uart_io.sv
// Z80 I/O-bus UART register block: RX/TX byte FIFOs, IM2 vector register and
// maskable RX-available / TX-empty interrupts in front of the uart_rx/uart_tx cores.
module z80_uart_io #(
    parameter logic [7:0]  IO_BASE      = 8'h00,
    parameter int unsigned FIFO_AW      = 4,
    parameter logic [7:0]  IVEC_DEFAULT = 8'h6C
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic [7:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic       IORQ_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic       M1_n,
    output logic       INT_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic       rx_clear,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_ready
);
    localparam int unsigned Depth = 2 ** FIFO_AW;
    typedef logic [FIFO_AW:0] ptr_t;
    typedef enum logic [1:0] {TIdle, TSend, TBusy, TDone} tx_state_e;

    logic [7:0] offset, d_out_q, vector_q, tx_data_q, rd_mux, status;
    logic       in_range, rd_sel, wr_sel, ack_sel, rd_sel_q, wr_sel_q, ack_sel_q;
    logic       rd_start, wr_start, ack_start, sel_data, sel_ctrl, sel_vec, flush;
    logic       rx_ie_q, tx_ie_q, rx_overrun_q, tx_drop_q, rx_clear_q, int_n_q;
    logic       rx_empty, rx_full, rx_in, rx_push, rx_pop, rx_ovf;
    logic       tx_fifo_empty, tx_full, tx_push, tx_pop, tx_ovf, tx_empty;
    logic       irq_rx, irq_tx, src;
    ptr_t       rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
    logic [7:0] rx_mem [Depth];
    logic [7:0] tx_mem [Depth];
    tx_state_e  tx_state_q, tx_state_d;

    // Offset subtraction keeps the decode correct for any base, including wrap at 8'hFF.
    assign offset    = A - IO_BASE;
    assign in_range  = offset <= 8'd2;
    assign sel_data  = offset == 8'd0;
    assign sel_ctrl  = offset == 8'd1;
    assign sel_vec   = offset == 8'd2;
    assign rd_sel    = ~IORQ_n & ~RD_n & M1_n & in_range;
    assign wr_sel    = ~IORQ_n & ~WR_n & in_range;
    assign ack_sel   = ~M1_n & ~IORQ_n;
    assign rd_start  = rd_sel & ~rd_sel_q;
    assign wr_start  = wr_sel & ~wr_sel_q;
    assign ack_start = ack_sel & ~ack_sel_q;
    assign flush     = wr_start & sel_ctrl & D_in[7];

    assign rx_empty = rx_wr_q == rx_rd_q;
    assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                      (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
    assign rx_pop   = rd_start & sel_data & ~rx_empty;
    assign rx_in    = rx_data_ready & ~rx_clear_q;
    assign rx_push  = rx_in & (~rx_full | rx_pop);
    assign rx_ovf   = rx_in & rx_full & ~rx_pop;

    assign tx_fifo_empty = tx_wr_q == tx_rd_q;
    assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                      (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
    assign tx_push  = wr_start & sel_data & (~tx_full | tx_pop);
    assign tx_ovf   = wr_start & sel_data & tx_full & ~tx_pop;
    assign tx_empty = tx_fifo_empty & (tx_state_q == TIdle) & tx_ready;

    assign irq_rx = rx_ie_q & ~rx_empty;
    assign irq_tx = tx_ie_q & tx_empty;
    assign src    = ~irq_rx & irq_tx;

    // rx_avail and tx_space sit in bits [2:1] where legacy BASIC code polls them.
    assign status = {tx_drop_q, rx_overrun_q, 2'b00, tx_empty, ~tx_full, ~rx_empty, 1'b0};

    always_comb begin
        rd_mux = 8'h00;
        if (sel_data && !rx_empty) begin
            rd_mux = rx_mem[rx_rd_q[FIFO_AW-1:0]];
        end else if (sel_ctrl) begin
            rd_mux = status;
        end else if (sel_vec) begin
            rd_mux = vector_q;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_pop     = 1'b0;
        tx_send    = 1'b0;
        unique case (tx_state_q)
            TIdle: if (!tx_fifo_empty && tx_ready && !flush) begin
                tx_pop     = 1'b1;
                tx_state_d = TSend;
            end
            TSend: begin
                tx_send    = 1'b1;
                tx_state_d = TBusy;
            end
            TBusy: if (!tx_ready) tx_state_d = TDone;
            TDone: if (tx_ready) tx_state_d = TIdle;
            default: tx_state_d = TIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n || flush) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wr_q[FIFO_AW-1:0]] <= rx_data;
        if (tx_push) tx_mem[tx_wr_q[FIFO_AW-1:0]] <= D_in;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            rd_sel_q     <= 1'b0;
            wr_sel_q     <= 1'b0;
            ack_sel_q    <= 1'b0;
            rx_ie_q      <= 1'b0;
            tx_ie_q      <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
            rx_clear_q   <= 1'b0;
            int_n_q      <= 1'b1;
            d_out_q      <= 8'h00;
            vector_q     <= IVEC_DEFAULT;
            tx_data_q    <= 8'h00;
            tx_state_q   <= TIdle;
        end else begin
            rd_sel_q   <= rd_sel;
            wr_sel_q   <= wr_sel;
            ack_sel_q  <= ack_sel;
            rx_clear_q <= rx_data_ready;
            int_n_q    <= ~(irq_rx | irq_tx);
            tx_state_q <= tx_state_d;
            if (wr_start && sel_ctrl) begin
                rx_ie_q <= D_in[0];
                tx_ie_q <= D_in[1];
            end
            if (wr_start && sel_vec) vector_q <= D_in;
            if (flush) begin
                rx_overrun_q <= 1'b0;
                tx_drop_q    <= 1'b0;
            end else begin
                if (rx_ovf) rx_overrun_q <= 1'b1;
                if (tx_ovf) tx_drop_q    <= 1'b1;
            end
            if (ack_start) begin
                d_out_q <= {vector_q[7:2], src, vector_q[0]};
            end else if (rd_start) begin
                d_out_q <= rd_mux;
            end
            if (tx_pop) tx_data_q <= tx_mem[tx_rd_q[FIFO_AW-1:0]];
        end
    end

    assign D_out    = d_out_q;
    assign D_oe     = rd_sel | ack_sel;
    assign INT_n    = int_n_q;
    assign rx_clear = rx_clear_q;
    assign tx_data  = tx_data_q;
endmodule

// File: tb/tb_z80_uart_io.sv
// Directed bench for z80_uart_io: register table, RX/TX FIFO paths, flush,
// overrun/drop flags and IM2 acknowledge vectors, with a simple uart_tx model.
module tb_z80_uart_io;
    localparam logic [7:0] Base = 8'h00;

    logic       CLK = 1'b0;
    logic       RESET_n, IORQ_n, RD_n, WR_n, M1_n, D_oe, INT_n;
    logic       rx_data_ready, rx_clear, tx_send;
    logic       tx_ready = 1'b0;
    logic       tx_hold = 1'b1;
    logic [7:0] A, D_in, D_out, rx_data, tx_data;

    int tests = 0;
    int fails = 0;
    int tx_busy = 0;
    int tx_viol = 0;
    logic tx_rise = 1'b0;
    logic tx_ready_prev = 1'b0;
    logic [7:0] sent[$];

    z80_uart_io #(.IO_BASE(Base), .FIFO_AW(4), .IVEC_DEFAULT(8'h6C)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n), .M1_n(M1_n), .INT_n(INT_n),
        .rx_data(rx_data), .rx_data_ready(rx_data_ready), .rx_clear(rx_clear),
        .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready)
    );

    always #5 CLK = ~CLK;

    // uart_tx model: a send strobe drops tx_ready for three cycles.
    always @(negedge CLK) begin
        if (tx_ready && !tx_ready_prev) tx_rise = 1'b1;
        tx_ready_prev = tx_ready;
        if (tx_send) begin
            if (!tx_rise) tx_viol++;
            tx_rise = 1'b0;
            sent.push_back(tx_data);
            tx_busy  <= 3;
            tx_ready <= 1'b0;
        end else if (tx_busy > 1) begin
            tx_busy <= tx_busy - 1;
        end else begin
            tx_busy  <= 0;
            tx_ready <= !tx_hold;
        end
    end

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        logic       exp_oe;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic io_read(input logic [7:0] addr, input int hold,
                           output logic [7:0] data, output logic oe);
        A = addr; IORQ_n = 1'b0; RD_n = 1'b0; M1_n = 1'b1;
        repeat (hold) @(negedge CLK);
        data = D_out;
        oe   = D_oe;
        IORQ_n = 1'b1; RD_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        A = addr; D_in = data; IORQ_n = 1'b0; WR_n = 1'b0;
        repeat (3) @(negedge CLK);
        IORQ_n = 1'b1; WR_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic rd_check(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        io_read(addr, 3, d, oe);
        check(name, {oe, d}, {1'b1, exp});
    endtask

    task automatic ack_check(input string name, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        IORQ_n = 1'b0; M1_n = 1'b0;
        repeat (2) @(negedge CLK);
        d  = D_out;
        oe = D_oe;
        IORQ_n = 1'b1; M1_n = 1'b1;
        @(negedge CLK);
        check(name, {oe, d}, {1'b1, exp});
    endtask

    task automatic inject(input logic [7:0] b);
        int n = 0;
        while (rx_clear && n < 20) begin @(negedge CLK); n++; end
        rx_data = b; rx_data_ready = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!rx_clear && n < 20);
        if (!rx_clear) check("rx_handshake_timeout", rx_clear, 1'b1);
        rx_data_ready = 1'b0;
        @(negedge CLK);
    endtask

    vec_t       tbl[8];
    logic [7:0] d;
    logic       oe;
    int         bad;
    int         n;

    initial begin
        tbl[0] = '{1'b0, Base + 8'd1, 8'h00, 8'h04, 1'b1};
        tbl[1] = '{1'b0, Base + 8'd2, 8'h00, 8'h6C, 1'b1};
        tbl[2] = '{1'b1, Base + 8'd2, 8'hA5, 8'h00, 1'b0};
        tbl[3] = '{1'b0, Base + 8'd2, 8'h00, 8'hA5, 1'b1};
        tbl[4] = '{1'b1, Base + 8'd2, 8'h5A, 8'h00, 1'b0};
        tbl[5] = '{1'b0, Base + 8'd2, 8'h00, 8'h5A, 1'b1};
        tbl[6] = '{1'b0, Base + 8'd0, 8'h00, 8'h00, 1'b1};
        tbl[7] = '{1'b0, Base + 8'd3, 8'h00, 8'h00, 1'b0};

        RESET_n = 1'b0; A = 8'h00; D_in = 8'h00; IORQ_n = 1'b1; RD_n = 1'b1;
        WR_n = 1'b1; M1_n = 1'b1; rx_data = 8'h00; rx_data_ready = 1'b0;
        repeat (4) @(negedge CLK);
        RESET_n = 1'b1;
        @(negedge CLK);
        check("reset_outputs", {INT_n, D_oe, rx_clear, tx_send, D_out, tx_data},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) begin
                io_write(tbl[i].addr, tbl[i].data);
            end else begin
                io_read(tbl[i].addr, 3, d, oe);
                check($sformatf("tbl%0d_oe", i), oe, tbl[i].exp_oe);
                if (tbl[i].exp_oe) check($sformatf("tbl%0d_data", i), d, tbl[i].exp);
            end
        end
        check("int_idle", INT_n, 1'b1);

        tx_hold = 1'b0;
        repeat (3) @(negedge CLK);
        rd_check("status_tx_ready", Base + 8'd1, 8'h0C);

        // RX interrupt and single pop per held read
        inject(8'h41); inject(8'h42); inject(8'h43);
        rd_check("status_rx_avail", Base + 8'd1, 8'h0E);
        check("int_masked", INT_n, 1'b1);
        io_write(Base + 8'd1, 8'h01);
        repeat (2) @(negedge CLK);
        check("int_rx_on", INT_n, 1'b0);
        io_read(Base, 4, d, oe);
        check("rx_read0", d, 8'h41);
        check("int_still_on", INT_n, 1'b0);
        io_read(Base, 4, d, oe);
        check("rx_read1", d, 8'h42);
        io_read(Base, 4, d, oe);
        check("rx_read2", d, 8'h43);
        repeat (2) @(negedge CLK);
        check("int_rx_off", INT_n, 1'b1);
        rd_check("rx_empty_read", Base, 8'h00);

        // RX overrun: 17th byte discarded
        for (int i = 0; i < 17; i++) inject(8'h10 + 8'(i));
        rd_check("status_overrun", Base + 8'd1, 8'h4E);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            io_read(Base, 3, d, oe);
            if (d !== 8'h10 + 8'(i)) bad++;
        end
        check("rx_overrun_order", bad, 0);
        rd_check("rx_17th_dropped", Base, 8'h00);
        inject(8'h99);
        io_write(Base + 8'd1, 8'h80);
        rd_check("status_after_flush", Base + 8'd1, 8'h0C);

        // TX drop with tx_ready stalled, then drain in order
        tx_hold = 1'b1;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 20; i++) io_write(Base, 8'h30 + 8'(i));
        rd_check("status_tx_drop", Base + 8'd1, 8'h80);
        check("tx_no_send_stalled", sent.size(), 0);
        tx_hold = 1'b0;
        n = 0;
        while (sent.size() < 16 && n < 3000) begin @(negedge CLK); n++; end
        repeat (20) @(negedge CLK);
        check("tx_count", sent.size(), 16);
        bad = 0;
        for (int i = 0; i < 16 && i < sent.size(); i++) if (sent[i] !== 8'h30 + 8'(i)) bad++;
        check("tx_order", bad, 0);
        check("tx_handshake", tx_viol, 0);
        rd_check("status_tx_done", Base + 8'd1, 8'h8C);
        io_write(Base + 8'd1, 8'h80);
        rd_check("status_drop_clr", Base + 8'd1, 8'h0C);

        // IM2 acknowledge vectors, RX before TX
        io_write(Base + 8'd2, 8'h80);
        io_write(Base + 8'd1, 8'h03);
        inject(8'h55);
        repeat (2) @(negedge CLK);
        check("int_both", INT_n, 1'b0);
        ack_check("ack_rx", 8'h80);
        rd_check("ack_no_pop", Base + 8'd1, 8'h0E);
        rd_check("rx_after_ack", Base, 8'h55);
        repeat (2) @(negedge CLK);
        check("int_tx", INT_n, 1'b0);
        ack_check("ack_tx", 8'h82);
        io_write(Base + 8'd1, 8'h00);
        repeat (2) @(negedge CLK);
        check("int_ie_clr", INT_n, 1'b1);

        // Same-cycle push and pop on a full RX FIFO
        for (int i = 0; i < 16; i++) inject(8'h60 + 8'(i));
        rx_data = 8'h70; rx_data_ready = 1'b1;
        A = Base; IORQ_n = 1'b0; RD_n = 1'b0; M1_n = 1'b1;
        @(negedge CLK);
        rx_data_ready = 1'b0;
        repeat (2) @(negedge CLK);
        check("full_pushpop_data", D_out, 8'h60);
        IORQ_n = 1'b1; RD_n = 1'b1;
        repeat (2) @(negedge CLK);
        rd_check("full_pushpop_status", Base + 8'd1, 8'h0E);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            io_read(Base, 3, d, oe);
            if (d !== ((i == 15) ? 8'h70 : 8'h61 + 8'(i))) bad++;
        end
        check("full_pushpop_order", bad, 0);
        rd_check("full_pushpop_empty", Base + 8'd1, 8'h0C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
